i2c_sync_fifo: RTL

Synchronous first-word-fall-through FIFO that buffers bytes between the register interface and the I2C master core.
- Transmit instance: its head byte drives the master's data_i; its empty flag drives trans_fifo_empty_i.
- Receive instance: it is written with bytes the master shifts in from SDA; its full flag drives rev_fifo_full_i.
- Both instances run in the i2c_core_clock_i domain.

---
 rtl/i2c_pkg.sv | 10 +
 rtl/i2c_fifo_mem.sv | 27 ++
 rtl/i2c_sync_fifo.sv | 99 +++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C master datapath.
// Both byte FIFOs take their default sizing from here.
package i2c_pkg;

  localparam int I2C_DATA_WIDTH      = 8;
  localparam int I2C_FIFO_ADDR_WIDTH = 4;
  localparam int I2C_FIFO_DEPTH      = 2 ** I2C_FIFO_ADDR_WIDTH;
  localparam int I2C_FIFO_AFULL      = 12;

endpackage

// File: rtl/i2c_fifo_mem.sv
// Register-array storage for the I2C byte FIFOs.
// It has one synchronous write port and one asynchronous read port. The array is not reset.
module i2c_fifo_mem
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int ADDR_WIDTH = I2C_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/i2c_sync_fifo.sv
// First-word-fall-through byte FIFO for the I2C master.
// Occupancy is tracked in a registered count, and the full/empty flags come from that count.
module i2c_sync_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH  = I2C_DATA_WIDTH,
  parameter int ADDR_WIDTH  = I2C_FIFO_ADDR_WIDTH,
  parameter int AFULL_LEVEL = I2C_FIFO_AFULL
) (
  input  logic                  i2c_core_clock_i,
  input  logic                  reset_bit_i,
  input  logic                  clear_i,
  input  logic                  write_en_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  read_en_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok, mem_we;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == DEPTH_CNT);
  assign almost_full_o = (count_q >= AFULL_CNT);
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;

  // A push while full is accepted only when a pop frees a slot in the same cycle.
  assign pop_ok  = read_en_i && !empty_o;
  assign push_ok = write_en_i && (!full_o || pop_ok);
  assign mem_we  = push_ok && !clear_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{ADDR_WIDTH{1'b0}}, push_ok} - {{ADDR_WIDTH{1'b0}}, pop_ok};
      if (write_en_i && !push_ok)  overflow_d  = 1'b1;
      if (read_en_i && empty_o)    underflow_d = 1'b1;
    end
  end

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  i2c_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (i2c_core_clock_i),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (write_data_i),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

  assign read_data_o = empty_o ? '0 : mem_rd_data;

endmodule
